// File: rtl/cva6_regfile_pkg.sv
// Shared types and helpers for the multi-write-port LVT register file.
package cva6_regfile_pkg;

  // Minimal core configuration: only provides the default data width.
  typedef struct packed {
    logic [31:0] xlen;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{xlen: 32'd32};

  // Clear sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1
  } clr_state_e;

  // Width of one live-value-table entry (bank index).
  function automatic int lvt_width(input int n);
    return (n == 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cva6_regfile_bank.sv
// One RAM bank: single write port, NR_READ_PORTS read ports.
// No reset on the storage so it maps onto distributed or block RAM.
module cva6_regfile_bank #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned NR_READ_PORTS = 2,
  parameter bit          SYNC_READ     = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i [NR_READ_PORTS],
  output logic [DATA_WIDTH-1:0] rdata_o [NR_READ_PORTS]
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Single write port into the storage array.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  for (genvar k = 0; k < NR_READ_PORTS; k++) begin : g_rd
    if (SYNC_READ) begin : g_sync
      logic [DATA_WIDTH-1:0] rdata_q;
      // BRAM-style registered read; returns the pre-write value on a collision.
      always_ff @(posedge clk_i) begin
        rdata_q <= mem[raddr_i[k]];
      end
      assign rdata_o[k] = rdata_q;
    end else begin : g_async
      assign rdata_o[k] = mem[raddr_i[k]];
    end
  end

endmodule

// File: rtl/cva6_regfile_lvt.sv
// Multi-write-port register file: one RAM bank per write port plus a
// live-value table naming the bank that holds each entry's latest value.
// A clear sweep zeroes bank 0 and the LVT after reset or on clear_i.
// Clear protocol: clear_i is a one-cycle request accepted in any state;
// busy_o stays high until every entry has been rewritten, and while it is
// high writes are discarded and all read data is forced to zero.
module cva6_regfile_lvt
  import cva6_regfile_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg        = cva6_cfg_empty,
  parameter int unsigned DATA_WIDTH     = CVA6Cfg.xlen,
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned NR_READ_PORTS  = 2,
  parameter int unsigned NR_WRITE_PORTS = 2,
  parameter bit          SYNC_READ      = 1'b0,
  parameter bit          ZERO_REG_ZERO  = 1'b0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  output logic                      busy_o,
  input  logic [ADDR_WIDTH-1:0]     raddr_i [NR_READ_PORTS],
  output logic [DATA_WIDTH-1:0]     rdata_o [NR_READ_PORTS],
  input  logic [ADDR_WIDTH-1:0]     waddr_i [NR_WRITE_PORTS],
  input  logic [DATA_WIDTH-1:0]     wdata_i [NR_WRITE_PORTS],
  input  logic [NR_WRITE_PORTS-1:0] we_i
);

  localparam int unsigned NUM_WORDS = 2**ADDR_WIDTH;
  localparam int unsigned LVT_W     = lvt_width(NR_WRITE_PORTS);

  clr_state_e              state_q;
  logic                    busy_q;
  logic [ADDR_WIDTH-1:0]   cnt_q;
  logic [LVT_W-1:0]        lvt_q [NUM_WORDS];

  logic [NR_WRITE_PORTS-1:0] bank_we;
  logic [ADDR_WIDTH-1:0]     bank_waddr [NR_WRITE_PORTS];
  logic [DATA_WIDTH-1:0]     bank_wdata [NR_WRITE_PORTS];
  logic [DATA_WIDTH-1:0]     bank_rdata [NR_WRITE_PORTS][NR_READ_PORTS];

  logic [ADDR_WIDTH-1:0]     rd_addr  [NR_READ_PORTS];
  logic [NR_READ_PORTS-1:0]  fwd_hit;
  logic [DATA_WIDTH-1:0]     fwd_data [NR_READ_PORTS];

  assign busy_o = busy_q;

  // Effective bank writes: user ports gated by busy/clear/zero-register,
  // with the clear sweep taking over bank 0 while sweeping.
  always_comb begin
    for (int j = 0; j < NR_WRITE_PORTS; j++) begin
      bank_we[j]    = we_i[j] && !busy_q && !clear_i &&
                      !(ZERO_REG_ZERO && (waddr_i[j] == '0));
      bank_waddr[j] = waddr_i[j];
      bank_wdata[j] = wdata_i[j];
    end
    if (state_q == CLEAR) begin
      bank_we[0]    = 1'b1;
      bank_waddr[0] = cnt_q;
      bank_wdata[0] = '0;
    end
  end

  // Clear sequencer: sweeps every address once; clear_i restarts the sweep.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (clear_i) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          if (clear_i) begin
            cnt_q <= '0;
          end else if (cnt_q == '1) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + ADDR_WIDTH'(1);
          end
        end
        default: begin
          state_q <= CLEAR;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  // Live-value table: the highest-numbered bank writing an address owns it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int a = 0; a < NUM_WORDS; a++) lvt_q[a] <= '0;
    end else begin
      for (int j = 0; j < NR_WRITE_PORTS; j++) begin
        if (bank_we[j]) lvt_q[bank_waddr[j]] <= LVT_W'(j);
      end
    end
  end

  for (genvar j = 0; j < NR_WRITE_PORTS; j++) begin : g_bank
    cva6_regfile_bank #(
      .DATA_WIDTH    (DATA_WIDTH),
      .ADDR_WIDTH    (ADDR_WIDTH),
      .NR_READ_PORTS (NR_READ_PORTS),
      .SYNC_READ     (SYNC_READ)
    ) i_bank (
      .clk_i   (clk_i),
      .we_i    (bank_we[j]),
      .waddr_i (bank_waddr[j]),
      .wdata_i (bank_wdata[j]),
      .raddr_i (raddr_i),
      .rdata_o (bank_rdata[j])
    );
  end

  for (genvar k = 0; k < NR_READ_PORTS; k++) begin : g_rport
    if (SYNC_READ) begin : g_sync
      logic [ADDR_WIDTH-1:0] raddr_q;
      logic                  hit_d, hit_q;
      logic [DATA_WIDTH-1:0] data_d, data_q;

      // Write-first bypass: catch any bank write to the address being sampled.
      always_comb begin
        hit_d  = 1'b0;
        data_d = '0;
        for (int j = 0; j < NR_WRITE_PORTS; j++) begin
          if (bank_we[j] && (bank_waddr[j] == raddr_i[k])) begin
            hit_d  = 1'b1;
            data_d = bank_wdata[j];
          end
        end
      end

      // Registered read address and bypass data, aligned with the bank output.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          raddr_q <= '0;
          hit_q   <= 1'b0;
          data_q  <= '0;
        end else begin
          raddr_q <= raddr_i[k];
          hit_q   <= hit_d;
          data_q  <= data_d;
        end
      end

      assign rd_addr[k]  = raddr_q;
      assign fwd_hit[k]  = hit_q;
      assign fwd_data[k] = data_q;
    end else begin : g_async
      assign rd_addr[k]  = raddr_i[k];
      assign fwd_hit[k]  = 1'b0;
      assign fwd_data[k] = '0;
    end
  end

  // Output mux: LVT-selected bank, then bypass, then zero/busy masking.
  always_comb begin
    for (int k = 0; k < NR_READ_PORTS; k++) begin
      rdata_o[k] = '0;
      for (int j = 0; j < NR_WRITE_PORTS; j++) begin
        if (lvt_q[rd_addr[k]] == LVT_W'(j)) rdata_o[k] = bank_rdata[j][k];
      end
      if (fwd_hit[k]) rdata_o[k] = fwd_data[k];
      if (busy_q || (ZERO_REG_ZERO && (rd_addr[k] == '0))) rdata_o[k] = '0;
    end
  end

endmodule
